// File: rtl/ysyx_220053_csr.sv
// ysyx_220053_csr: machine-mode CSR file (mstatus, mtvec, mepc, mcause) with RW/RS/RC writes and ecall trap entry.
// Optional mscratch at 0x340 enabled by defining YSYX_220053_MSCRATCH_EN.
`default_nettype none

module ysyx_220053_csr (
  input  logic        clk,
  input  logic        rst,
  input  logic        Csrwen,
  input  logic [2:0]  CsrOp,
  input  logic [11:0] CsrId,
  input  logic [63:0] datain,
  input  logic        Ecall,
  input  logic [63:0] epc_in,
  output logic [63:0] csrres,
  output logic [63:0] mtvec_o,
  output logic [63:0] mepc_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [63:0] MSTATUS_RST   = 64'h0000_000A_0000_1800;
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  logic [63:0] mstatus;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic [63:0] mcause;
  logic [63:0] wdata;
  logic        wen;

  // The immediate/register distinction is resolved upstream; bit 2 carries no meaning here.
  logic unused_op_imm;
  assign unused_op_imm = CsrOp[2];

`ifdef YSYX_220053_MSCRATCH_EN
  logic [63:0] mscratch;
`endif

  always_comb begin
    csrres = '0;
    case (CsrId)
      ADDR_MSTATUS:  csrres = mstatus;
      ADDR_MTVEC:    csrres = mtvec;
      ADDR_MEPC:     csrres = mepc;
      ADDR_MCAUSE:   csrres = mcause;
`ifdef YSYX_220053_MSCRATCH_EN
      ADDR_MSCRATCH: csrres = mscratch;
`endif
      default:       csrres = '0;
    endcase
  end

  always_comb begin
    wdata = csrres;
    case (CsrOp[1:0])
      2'b01:   wdata = datain;
      2'b10:   wdata = csrres | datain;
      2'b11:   wdata = csrres & ~datain;
      default: wdata = csrres;
    endcase
  end

  assign wen = Csrwen && (CsrOp[1:0] != 2'b00);

  // Trap entry owns mstatus/mepc/mcause in its cycle; mtvec is never touched by ecall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus <= MSTATUS_RST;
      mepc    <= '0;
      mcause  <= '0;
    end else if (Ecall) begin
      mepc          <= epc_in;
      mcause        <= CAUSE_ECALL_M;
      mstatus[7]    <= mstatus[3];
      mstatus[3]    <= 1'b0;
      mstatus[12:11] <= 2'b11;
    end else if (wen) begin
      case (CsrId)
        ADDR_MSTATUS: mstatus <= wdata;
        ADDR_MEPC:    mepc    <= wdata;
        ADDR_MCAUSE:  mcause  <= wdata;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtvec <= '0;
    end else if (wen && (CsrId == ADDR_MTVEC)) begin
      mtvec <= wdata;
    end
  end

`ifdef YSYX_220053_MSCRATCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mscratch <= '0;
    end else if (wen && (CsrId == ADDR_MSCRATCH)) begin
      mscratch <= wdata;
    end
  end
`endif

  assign mtvec_o = mtvec;
  assign mepc_o  = mepc;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_220053_csr.sv
// tb_ysyx_220053_csr: directed and randomized checks of ysyx_220053_csr against a behavioural CSR model.
`default_nettype none

module tb_ysyx_220053_csr;

`ifdef YSYX_220053_MSCRATCH_EN
  localparam bit MS_EN = 1'b1;
`else
  localparam bit MS_EN = 1'b0;
`endif
  localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;

  logic        clk;
  logic        rst;
  logic        Csrwen;
  logic [2:0]  CsrOp;
  logic [11:0] CsrId;
  logic [63:0] datain;
  logic        Ecall;
  logic [63:0] epc_in;
  logic [63:0] csrres;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_status, m_tvec, m_epc, m_cause, m_scratch;

  ysyx_220053_csr dut (
    .clk     (clk),
    .rst     (rst),
    .Csrwen  (Csrwen),
    .CsrOp   (CsrOp),
    .CsrId   (CsrId),
    .datain  (datain),
    .Ecall   (Ecall),
    .epc_in  (epc_in),
    .csrres  (csrres),
    .mtvec_o (mtvec_o),
    .mepc_o  (mepc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_status;
      12'h305: return m_tvec;
      12'h340: return MS_EN ? m_scratch : 64'd0;
      12'h341: return m_epc;
      12'h342: return m_cause;
      default: return 64'd0;
    endcase
  endfunction

  function automatic void m_reset();
    m_status = MSTATUS_RST;
    m_tvec = 0; m_epc = 0; m_cause = 0; m_scratch = 0;
  endfunction

  // Architectural effect of one clock edge given the inputs.
  function automatic void m_step(input logic wen, input logic [2:0] op, input logic [11:0] id,
                                 input logic [63:0] din, input logic ecall, input logic [63:0] epc);
    logic [63:0] old, nv;
    bit do_wr;
    old = m_read(id);
    case (op[1:0])
      2'd1: nv = din;
      2'd2: nv = old | din;
      2'd3: nv = old & ~din;
      default: nv = old;
    endcase
    do_wr = wen && (op[1:0] != 2'd0);
    if (ecall) begin
      m_epc = epc;
      m_cause = 64'd11;
      m_status[7] = m_status[3];
      m_status[3] = 1'b0;
      m_status[12:11] = 2'b11;
    end
    if (do_wr) begin
      if (id == 12'h305) m_tvec = nv;
      if (id == 12'h340 && MS_EN) m_scratch = nv;
      if (!ecall) begin
        if (id == 12'h300) m_status = nv;
        if (id == 12'h341) m_epc = nv;
        if (id == 12'h342) m_cause = nv;
      end
    end
  endfunction

  task automatic cyc(input logic wen, input logic [2:0] op, input logic [11:0] id,
                     input logic [63:0] din, input logic ecall, input logic [63:0] epc);
    @(negedge clk);
    Csrwen = wen; CsrOp = op; CsrId = id; datain = din; Ecall = ecall; epc_in = epc;
    #1;
    chk("csrres_pre", csrres, m_read(id));
    m_step(wen, op, id, din, ecall, epc);
    @(posedge clk);
    #1;
    chk("mtvec_o", mtvec_o, m_tvec);
    chk("mepc_o", mepc_o, m_epc);
  endtask

  task automatic rd(input string tag, input logic [11:0] id, input logic [63:0] exp);
    @(negedge clk);
    Csrwen = 1'b0; Ecall = 1'b0; CsrOp = 3'b000; CsrId = id;
    #1;
    chk(tag, csrres, exp);
  endtask

  logic [11:0] addr_tab [6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0};

  initial begin
    rst = 1'b0; Csrwen = 1'b0; CsrOp = 3'b000; CsrId = 12'h300;
    datain = '0; Ecall = 1'b0; epc_in = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    rd("rst_mstatus", 12'h300, MSTATUS_RST);
    chk("rst_mtvec_o", mtvec_o, 64'd0);
    chk("rst_mepc_o", mepc_o, 64'd0);

    // RW mtvec: old value on csrres in the write cycle, new value next cycle.
    cyc(1, 3'b001, 12'h305, 64'h8000_0100, 0, 0);
    chk("rw_mtvec", mtvec_o, 64'h8000_0100);

    cyc(0, 3'b000, 12'h300, 0, 1, 64'h8000_0040);
    chk("ecall_mepc", mepc_o, 64'h8000_0040);
    rd("ecall_mcause", 12'h342, 64'd11);
    rd("ecall_mstatus", 12'h300, MSTATUS_RST);

    cyc(1, 3'b001, 12'h305, 64'hF0, 0, 0);
    cyc(1, 3'b010, 12'h305, 64'h0F, 0, 0);
    chk("rs_mtvec", mtvec_o, 64'hFF);
    cyc(1, 3'b011, 12'h305, 64'hF0, 0, 0);
    chk("rc_mtvec", mtvec_o, 64'h0F);
    cyc(0, 3'b001, 12'h305, 64'h123, 0, 0);
    chk("nowen_mtvec", mtvec_o, 64'h0F);
    cyc(1, 3'b110, 12'h305, 64'h0, 0, 0);
    chk("rs_zero_mtvec", mtvec_o, 64'h0F);

    cyc(1, 3'b001, 12'h7C0, 64'd5, 0, 0);
    rd("unimpl_read", 12'h7C0, 64'd0);
    cyc(1, 3'b001, 12'h341, 64'd1, 1, 64'h8000_0ABC);
    chk("ecall_wins_mepc", mepc_o, 64'h8000_0ABC);

    // Set MIE, then trap: MPIE takes old MIE, MIE clears.
    cyc(1, 3'b110, 12'h300, 64'h8, 0, 0);
    rd("mie_set", 12'h300, MSTATUS_RST | 64'h8);
    cyc(1, 3'b001, 12'h305, 64'h200, 1, 64'h44);
    rd("ecall_mpie", 12'h300, MSTATUS_RST | 64'h80);
    chk("ecall_mtvec_wr", mtvec_o, 64'h200);

    cyc(1, 3'b101, 12'h340, 64'h1234, 0, 0);
    rd("mscratch", 12'h340, MS_EN ? 64'h1234 : 64'd0);

    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 9) < 9) ? addr_tab[$urandom_range(0, 5)] : 12'($urandom);
      cyc(($urandom_range(0, 3) != 0), 3'($urandom), a,
          ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom},
          ($urandom_range(0, 7) == 0), {$urandom, $urandom});
    end

    // Make sure state is non-reset before the asynchronous reset test.
    cyc(1, 3'b001, 12'h305, 64'hABC0, 0, 0);
    cyc(1, 3'b001, 12'h341, 64'h5550, 0, 0);
    @(negedge clk);
    Csrwen = 1'b1; CsrOp = 3'b001; CsrId = 12'h305; datain = 64'hDEAD; Ecall = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_mtvec_o", mtvec_o, 64'd0);
    chk("arst_mepc_o", mepc_o, 64'd0);
    CsrId = 12'h300; #1;
    chk("arst_mstatus", csrres, MSTATUS_RST);
    CsrId = 12'h342; #1;
    chk("arst_mcause", csrres, 64'd0);
    CsrId = 12'h340; Ecall = 1'b1; epc_in = 64'h77;
    @(posedge clk); #1;
    chk("arst_hold_mepc", mepc_o, 64'd0);
    chk("arst_hold_mtvec", mtvec_o, 64'd0);
    chk("arst_mscratch", csrres, 64'd0);
    @(negedge clk);
    Csrwen = 1'b0; Ecall = 1'b0;
    rst = 1'b1;
    m_reset();
    cyc(1, 3'b001, 12'h305, 64'h8000_0000, 0, 0);
    chk("post_rst_mtvec", mtvec_o, 64'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
